// File: rtl/fc_mac_array.sv
// fc_mac_array: multi-lane fully-connected MAC engine.
// One activation per beat is broadcast to NUM_LANES signed MAC lanes, each with
// its own weight. At the end of a vector each lane adds its bias, applies a
// round-half-up arithmetic shift, then optional ReLU and output saturation.
// The result is held on a valid/ready port until the consumer accepts it.
module fc_mac_array #(
  parameter int NUM_LANES = 4,
  parameter int IN_W      = 8,
  parameter int ACC_W     = 32,
  parameter int BIAS_W    = 32,
  parameter int OUT_W     = 8,
  parameter int SHIFT_W   = 5
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic                           in_last_i,
  input  logic [IN_W-1:0]                pixel_i,
  input  logic [NUM_LANES*IN_W-1:0]      weight_i,
  input  logic [NUM_LANES*BIAS_W-1:0]    bias_i,
  input  logic [SHIFT_W-1:0]             shift_i,
  input  logic                           relu_en_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [NUM_LANES*OUT_W-1:0]     out_data_o,
  output logic [NUM_LANES*ACC_W-1:0]     out_acc_o,
  output logic [NUM_LANES-1:0]           ovf_o
);

  // Two guard bits: one for acc+bias, one for the rounding increment.
  localparam int SW = ACC_W + 2;

  typedef enum logic [1:0] {
    ST_ACC,
    ST_POST,
    ST_OUT
  } state_t;

  state_t                      state;
  logic signed [ACC_W-1:0]     acc_q    [NUM_LANES];
  logic signed [ACC_W-1:0]     acc_next [NUM_LANES];
  logic [NUM_LANES-1:0]        ovf_hit;
  logic [NUM_LANES*BIAS_W-1:0] bias_q;
  logic [SHIFT_W-1:0]          shift_q;
  logic                        relu_q;
  logic [NUM_LANES*OUT_W-1:0]  post_res;

  // Handshake flags are pure decodes of the state register, so neither
  // depends combinationally on the opposite side's valid/ready.
  assign in_ready_o  = (state == ST_ACC);
  assign out_valid_o = (state == ST_OUT);

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic signed [IN_W-1:0]   w;
    logic signed [2*IN_W-1:0] prod;
    logic [ACC_W:0]           sum;
    logic                     lane_ovf;
    logic [BIAS_W-1:0]        b;
    logic [SW-1:0]            s_bias;
    logic [SW-1:0]            rnd;
    logic [SW-1:0]            s_rnd;
    logic [SW-1:0]            s_shift;
    logic [SW-1:0]            s_relu;
    logic [SW-OUT_W:0]        upper;

    assign w        = weight_i[k*IN_W +: IN_W];
    assign prod     = (2*IN_W)'($signed(pixel_i)) * (2*IN_W)'(w);
    assign sum      = {acc_q[k][ACC_W-1], acc_q[k]}
                    + {{(ACC_W+1-2*IN_W){prod[2*IN_W-1]}}, prod};
    assign lane_ovf = sum[ACC_W] ^ sum[ACC_W-1];
    assign ovf_hit[k] = lane_ovf;
    assign acc_next[k] = lane_ovf
                       ? (sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                       : sum[ACC_W-1:0];

    assign b       = bias_q[k*BIAS_W +: BIAS_W];
    assign s_bias  = {{2{acc_q[k][ACC_W-1]}}, acc_q[k]}
                   + {{(SW-BIAS_W){b[BIAS_W-1]}}, b};
    assign rnd     = (shift_q == '0) ? '0 : (SW'(1) << (shift_q - SHIFT_W'(1)));
    assign s_rnd   = s_bias + rnd;
    assign s_shift = $signed(s_rnd) >>> shift_q;
    assign s_relu  = (relu_q && s_shift[SW-1]) ? '0 : s_shift;
    // The value fits OUT_W when all bits above the output sign bit agree.
    assign upper   = s_relu[SW-1:OUT_W-1];
    assign post_res[k*OUT_W +: OUT_W] = ((&upper) || !(|upper))
                   ? s_relu[OUT_W-1:0]
                   : (s_relu[SW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}});

    assign out_acc_o[k*ACC_W +: ACC_W] = acc_q[k];
  end

  // Control FSM plus accumulator, post-processing and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_ACC;
      for (int k = 0; k < NUM_LANES; k++) acc_q[k] <= '0;
      ovf_o      <= '0;
      bias_q     <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      out_data_o <= '0;
    end else begin
      case (state)
        ST_ACC: begin
          if (in_valid_i) begin
            for (int k = 0; k < NUM_LANES; k++) acc_q[k] <= acc_next[k];
            ovf_o <= ovf_o | ovf_hit;
            if (in_last_i) begin
              bias_q  <= bias_i;
              shift_q <= shift_i;
              relu_q  <= relu_en_i;
              state   <= ST_POST;
            end
          end
        end
        ST_POST: begin
          out_data_o <= post_res;
          state      <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready_i) begin
            for (int k = 0; k < NUM_LANES; k++) acc_q[k] <= '0;
            ovf_o <= '0;
            state <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_mac_array.sv
// tb_fc_mac_array: directed and randomised checks of fc_mac_array with a
// longint reference model feeding a scoreboard. A second instance with a
// 16-bit accumulator shares the stimulus for accumulator-saturation checks.
module tb_fc_mac_array;

  localparam int NL = 4;

  typedef struct {
    logic [NL*8-1:0]  data;
    logic [NL*32-1:0] acc;
    logic [NL-1:0]    ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic          in_last_i;
  logic [7:0]    pixel_i;
  logic [31:0]   weight_i;
  logic [127:0]  bias_i;
  logic [4:0]    shift_i;
  logic          relu_en_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [31:0]   out_data_o;
  logic [127:0]  out_acc_o;
  logic [3:0]    ovf_o;

  logic          in_ready16;
  logic          out_valid16;
  logic [31:0]   out_data16;
  logic [63:0]   out_acc16;
  logic [3:0]    ovf16;
  logic [63:0]   bias16;

  int            checks = 0;
  int            failures = 0;
  longint        m_acc [NL];
  logic [NL-1:0] m_ovf;
  exp_t          sb [$];

  // Free-running clock.
  always #5 clk = ~clk;

  fc_mac_array #(
    .NUM_LANES(4), .IN_W(8), .ACC_W(32), .BIAS_W(32), .OUT_W(8), .SHIFT_W(5)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_last_i(in_last_i), .pixel_i(pixel_i), .weight_i(weight_i), .bias_i(bias_i),
    .shift_i(shift_i), .relu_en_i(relu_en_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_acc_o(out_acc_o),
    .ovf_o(ovf_o)
  );

  fc_mac_array #(
    .NUM_LANES(4), .IN_W(8), .ACC_W(16), .BIAS_W(16), .OUT_W(8), .SHIFT_W(5)
  ) dut16 (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready16),
    .in_last_i(in_last_i), .pixel_i(pixel_i), .weight_i(weight_i), .bias_i(bias16),
    .shift_i(shift_i), .relu_en_i(relu_en_i), .out_valid_o(out_valid16),
    .out_ready_i(out_ready_i), .out_data_o(out_data16), .out_acc_o(out_acc16),
    .ovf_o(ovf16)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] expv);
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  function automatic logic [7:0] post_model(longint a, longint b, int sh, bit relu);
    longint s;
    s = a + b;
    if (sh > 0) s = (s + (longint'(1) << (sh - 1))) >>> sh;
    if (relu && s < 0) s = 0;
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
    return s[7:0];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NL; k++) m_acc[k] = 0;
    m_ovf = '0;
  endtask

  task automatic model_beat(input logic signed [7:0] px, input logic [31:0] w);
    for (int k = 0; k < NL; k++) begin
      logic signed [7:0] wk;
      longint t;
      wk = w[k*8 +: 8];
      t = m_acc[k] + longint'(px) * longint'(wk);
      if (t > 64'sd2147483647) begin
        t = 64'sd2147483647;
        m_ovf[k] = 1'b1;
      end else if (t < -64'sd2147483648) begin
        t = -64'sd2147483648;
        m_ovf[k] = 1'b1;
      end
      m_acc[k] = t;
    end
  endtask

  task automatic model_push();
    exp_t e;
    for (int k = 0; k < NL; k++) begin
      logic signed [31:0] bk;
      logic [63:0] a64;
      bk = bias_i[k*32 +: 32];
      a64 = m_acc[k];
      e.data[k*8 +: 8]   = post_model(m_acc[k], longint'(bk), int'(shift_i), relu_en_i);
      e.acc[k*32 +: 32]  = a64[31:0];
    end
    e.ovf = m_ovf;
    sb.push_back(e);
    model_clear();
  endtask

  // One cycle of input: a beat when valid=1, an idle gap otherwise.
  task automatic applyStimulus(input logic [7:0] px, input logic [31:0] w,
                               input bit last, input bit valid);
    pixel_i    = px;
    weight_i   = w;
    in_last_i  = last;
    in_valid_i = valid;
    if (valid) begin
      chk("beat_in_ready", in_ready_o, 1);
      model_beat(px, w);
      if (last) model_push();
    end
    step();
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic waitValid(input string tag);
    for (int i = 0; i < 20 && out_valid_o !== 1'b1; i++) step();
    chk({tag, "_valid"}, out_valid_o, 1);
  endtask

  task automatic checkReset(input string tag);
    chk({tag, "_in_ready"}, in_ready_o, 1);
    chk({tag, "_out_valid"}, out_valid_o, 0);
    chk({tag, "_out_data"}, out_data_o, 0);
    chk({tag, "_out_acc"}, out_acc_o, 0);
    chk({tag, "_ovf"}, ovf_o, 0);
  endtask

  // Wait for a result, stall the consumer, compare against the scoreboard,
  // then handshake while offering a beat that must be ignored.
  task automatic checkOutput(input string tag, input int stall);
    logic [31:0] held;
    exp_t e;
    waitValid(tag);
    held = out_data_o;
    for (int i = 0; i < stall; i++) begin
      step();
      chk({tag, "_stall_valid"}, out_valid_o, 1);
      chk({tag, "_stall_data"}, out_data_o, held);
      chk({tag, "_stall_in_ready"}, in_ready_o, 0);
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"}, out_data_o, e.data);
      chk({tag, "_acc"}, out_acc_o, e.acc);
      chk({tag, "_ovf"}, ovf_o, e.ovf);
    end
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    in_last_i   = 1'b1;
    pixel_i     = 8'h7f;
    weight_i    = 32'h7f7f7f7f;
    step();
    out_ready_i = 1'b0;
    in_valid_i  = 1'b0;
    in_last_i   = 1'b0;
    chk({tag, "_post_hs_valid"}, out_valid_o, 0);
    chk({tag, "_post_hs_in_ready"}, in_ready_o, 1);
    chk({tag, "_post_hs_acc"}, out_acc_o, 0);
    chk({tag, "_post_hs_ovf"}, ovf_o, 0);
  endtask

  // Directed sequence: reset, test-plan vectors, random vectors, resets.
  initial begin
    rst_i = 1'b1; in_valid_i = 1'b0; in_last_i = 1'b0; pixel_i = '0;
    weight_i = '0; bias_i = '0; shift_i = '0; relu_en_i = 1'b0;
    out_ready_i = 1'b0; bias16 = '0;
    model_clear();
    step(); step();
    rst_i = 1'b0;
    checkReset("reset");

    // Basic dot product with latency check.
    bias_i = {32'd0, 32'hFFFFFFFB, 32'd100, 32'd10};
    shift_i = 5'd2; relu_en_i = 1'b0;
    applyStimulus(8'd2, 32'h0007FF04, 0, 1);
    applyStimulus(8'd3, 32'h09FA0205, 1, 1);
    chk("lat_t1_valid", out_valid_o, 0);
    chk("lat_t1_in_ready", in_ready_o, 0);
    step();
    chk("lat_t2_valid", out_valid_o, 1);
    chk("basic_acc0", out_acc_o[31:0], 32'd23);
    chk("basic_out0", out_data_o[7:0], 8'd8);
    checkOutput("basic", 0);

    // Negative rounding, ReLU off then on, single-beat vectors.
    bias_i = '0; shift_i = 5'd2;
    relu_en_i = 1'b0;
    applyStimulus(8'd3, 32'h0101F501, 1, 1);
    waitValid("neg");
    chk("neg_out1", out_data_o[15:8], 8'hF8);
    checkOutput("neg", 1);
    relu_en_i = 1'b1;
    applyStimulus(8'd3, 32'h0101F501, 1, 1);
    waitValid("relu");
    chk("relu_out1", out_data_o[15:8], 8'h00);
    checkOutput("relu", 0);

    // Output saturation both directions.
    relu_en_i = 1'b0; shift_i = 5'd0;
    applyStimulus(8'd100, 32'hF60A0000, 1, 1);
    waitValid("osat");
    chk("osat_pos", out_data_o[23:16], 8'h7F);
    chk("osat_neg", out_data_o[31:24], 8'h80);
    chk("osat_ovf", ovf_o, 0);
    checkOutput("osat", 0);

    // Accumulator saturation on the 16-bit instance, then a clean vector.
    for (int b = 0; b < 3; b++) applyStimulus(8'd127, 32'h0000007F, b == 2, 1);
    waitValid("asat");
    chk("asat16_acc0", out_acc16[15:0], 16'h7FFF);
    chk("asat16_ovf", ovf16, 4'b0001);
    chk("asat16_out0", out_data16[7:0], 8'h7F);
    checkOutput("asat", 0);
    applyStimulus(8'd2, 32'h00000003, 1, 1);
    waitValid("asat_next");
    chk("asat16_next_acc0", out_acc16[15:0], 16'd6);
    chk("asat16_next_ovf", ovf16, 4'b0000);
    checkOutput("asat_next", 0);

    // Random vectors with input gaps and a 5-cycle output stall.
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k < NL; k++) bias_i[k*32 +: 32] = 32'($urandom_range(0, 4000)) - 32'd2000;
      shift_i   = 5'($urandom_range(0, 10));
      relu_en_i = 1'($urandom_range(0, 1));
      for (int b = 0; b < 6; b++) begin
        if ($urandom_range(0, 1) == 1) applyStimulus(8'($urandom), $urandom, 1, 0);
        applyStimulus(8'($urandom), $urandom, b == 5, 1);
      end
      checkOutput("rand", 5);
    end

    // Reset after 3 of 6 beats, with a beat offered in the reset cycle.
    bias_i = {4{32'd7}}; shift_i = 5'd1; relu_en_i = 1'b0;
    for (int b = 0; b < 3; b++) applyStimulus(8'd50, 32'h11223344, 0, 1);
    rst_i = 1'b1; in_valid_i = 1'b1; in_last_i = 1'b1; pixel_i = 8'd9;
    step();
    rst_i = 1'b0; in_valid_i = 1'b0; in_last_i = 1'b0;
    model_clear();
    checkReset("midrst");
    applyStimulus(8'd4, 32'h01020304, 0, 1);
    applyStimulus(8'hFD, 32'h05F00607, 1, 1);
    checkOutput("after_midrst", 0);

    // Reset while a result is pending, with out_ready high in that cycle.
    applyStimulus(8'd100, 32'h40404040, 1, 1);
    waitValid("outrst");
    rst_i = 1'b1; out_ready_i = 1'b1;
    step();
    rst_i = 1'b0; out_ready_i = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
    checkReset("outrst");
    applyStimulus(8'd6, 32'hFF020103, 0, 1);
    applyStimulus(8'd5, 32'h0304FE01, 1, 1);
    checkOutput("after_outrst", 2);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fc_mac_array.md
# fc_mac_array

Parametrised multi-lane fully-connected MAC engine, successor to the single-lane FC processing element. It broadcasts one activation per beat to `NUM_LANES` parallel signed MAC lanes, each with its own weight. At the end of a dot product it adds a per-lane bias, requantises with a rounding shift, and applies optional ReLU and saturation. The result is presented on a valid/ready output port. It sits between the FC activation/weight buffers and the output feature writer.

## Interface
Parameters:
- `NUM_LANES`, 4: parallel output neurons.
- `IN_W`, 8: signed activation/weight width.
- `ACC_W`, 32: signed accumulator width; must be ≥ 2*`IN_W`.
- `BIAS_W`, 32: signed bias width; must be ≤ `ACC_W`.
- `OUT_W`, 8: signed requantised output width.
- `SHIFT_W`, 5: requant shift-amount width.

Ports:
- `clk_i` in 1: single clock, all logic on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `in_valid_i` in 1: input beat valid.
- `in_ready_o` out 1: engine accepts a beat.
- `in_last_i` in 1: beat is the final term of the dot product.
- `pixel_i` in `IN_W`: signed activation, broadcast to all lanes.
- `weight_i` in `NUM_LANES*IN_W`: signed weights; lane k at bits [k*IN_W +: IN_W].
- `bias_i` in `NUM_LANES*BIAS_W`: signed per-lane bias; sampled on the last beat.
- `shift_i` in `SHIFT_W`: arithmetic right-shift amount; sampled on the last beat.
- `relu_en_i` in 1: ReLU enable; sampled on the last beat.
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: consumer accepts the result.
- `out_data_o` out `NUM_LANES*OUT_W`: requantised results, same lane packing.
- `out_acc_o` out `NUM_LANES*ACC_W`: raw per-lane accumulators (before bias), for debug.
- `ovf_o` out `NUM_LANES`: sticky per-lane accumulator-saturation flag for this vector.

## Operation
- FSM states:
  - ACC (reset state): `in_ready_o`=1.
  - POST: `in_ready_o`=0.
  - OUT: `in_ready_o`=0, `out_valid_o`=1.
- Beat handshake: `in_valid_i && in_ready_o`.
- ACC: each beat adds `pixel_i*weight_k` (full 2*`IN_W` signed product, sign-extended) into lane k's accumulator.
- Accumulator saturates at signed `ACC_W` limits. On saturation the lane's `ovf_o` bit sets and stays set until the vector completes.
- Last beat (`in_last_i`=1): its product is accumulated; `bias_i`, `shift_i` and `relu_en_i` are registered; ACC→POST.
- A beat with `in_valid_i`=0 has no effect. A vector of length 1 is legal.
- POST (one cycle), per lane, in this order:
  - s = acc + sign-extended bias, computed in `ACC_W`+1 bits without overflow.
  - If shift>0: s = (s + 2^(shift-1)) >>> shift (round half up toward +inf); if shift=0, no rounding.
  - If ReLU is enabled and s<0: s=0.
  - Saturate to signed `OUT_W`.
  - Register the result into `out_data_o`. POST→OUT.
- OUT: hold `out_data_o`, `out_acc_o` and `ovf_o` stable.
- On `out_ready_i`=1: OUT→ACC; accumulators and `ovf_o` clear to 0 on the same edge.
- Inputs presented while not in ACC are ignored; `in_ready_o`=0 there.

## Timing
- Reset values: state ACC, all accumulators 0, `in_ready_o`=1, `out_valid_o`=0, `out_data_o`=0, `out_acc_o`=0, `ovf_o`=0.
- Throughput: one beat per cycle in ACC, with no bubbles between beats.
- Latency: last beat accepted at edge T; `out_valid_o`=1 from T+2.
- Minimum vector-to-vector gap: 3 cycles.
  - Earliest output handshake is at T+2.
  - `in_ready_o`=1 again from T+3.
- `out_valid_o` never drops without a handshake. `out_data_o` is constant while valid and not yet accepted.
- `in_ready_o` does not depend combinationally on `in_valid_i`. `out_valid_o` does not depend combinationally on `out_ready_i`.
- Reset asserted in any state (mid-vector, in POST, or in OUT with a pending result): on the next edge, all state returns to reset values; the partial vector and any pending result are discarded.
- Reset has priority over every handshake in the same cycle.
- Simultaneous `out_ready_i` and new input in OUT: the input is not accepted (`in_ready_o`=0). The first new beat is taken on the following cycle.

## Test plan
- Basic dot product, lane 0:
  - Stimulus: pixels {2,3}, weights {4,5}, bias 10, shift 2, ReLU off.
  - Response: `out_acc_o`[0]=23; out = (33+2)>>>2 = 8. `out_valid_o` rises exactly 2 cycles after the last beat.
- Negative value, rounding and ReLU, lane 1:
  - Stimulus: acc=-33, bias 0, shift 2.
  - Response: ReLU off → -8; ReLU on → 0.
- Output saturation:
  - Stimulus: acc=1000, shift 0.
  - Response: 127. Same stimulus with acc=-1000 → -128. `ovf_o`=0 in both cases.
- Accumulator saturation, `ACC_W`=16:
  - Stimulus: 3 beats of 127*127.
  - Response: acc holds at 32767; `ovf_o` bit set. The next vector starts with acc=0 and `ovf_o`=0.
- Backpressure and gaps:
  - Stimulus: `in_valid_i` toggled randomly mid-vector; `out_ready_i` held low 5 cycles.
  - Response: result matches a reference model; `out_data_o` stable and `in_ready_o`=0 during the stall; next vector accepted one cycle after the handshake.
- Reset mid-operation:
  - Stimulus: `rst_i` pulsed after 3 of 6 beats, and separately while in OUT.
  - Response: all outputs at reset values on the next cycle. A following clean vector produces the correct result with no contamination from the aborted vector.
